// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Holds the four-state FSM encoding and the requester count.
package uart_arb_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter.sv
// Two-requester arbiter feeding one UART transmitter, with a tx_busy rise timeout.
// Define UART_ARB_ROUND_ROBIN_EN for round-robin contention handling; default is fixed priority to requester 0.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int DATA_W        = 8,
  parameter int BUSY_WAIT_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  output logic              grant_id,
  output logic              busy_err
);

  localparam int                CNT_W    = $clog2(BUSY_WAIT_MAX + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BUSY_WAIT_MAX - 1);

  arb_state_e         state;
  arb_state_e         state_next;
  logic [CNT_W-1:0]   wait_cnt;
  logic [CNT_W-1:0]   wait_cnt_next;
  logic [NUM_REQ-1:0] valid_vec;
  logic               winner;
  logic               grant_take;
  logic               busy_err_next;
`ifdef UART_ARB_ROUND_ROBIN_EN
  logic               last_grant;
`endif

  assign valid_vec = {req1_valid, req0_valid};

  // Winner is only consumed when at least one requester is valid.
  always_comb begin
`ifdef UART_ARB_ROUND_ROBIN_EN
    if (&valid_vec) winner = ~last_grant;
    else            winner = valid_vec[1];
`else
    winner = ~valid_vec[0];
`endif
  end

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_next    = state;
    wait_cnt_next = '0;
    busy_err_next = 1'b0;
    grant_take    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if ((|valid_vec) && !tx_busy) begin
          grant_take = 1'b1;
          state_next = ST_START;
        end
      end
      ST_START: begin
        state_next = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_next = ST_WAIT_DONE;
        end else if (wait_cnt == CNT_LAST) begin
          busy_err_next = 1'b1;
          state_next    = ST_IDLE;
        end else begin
          wait_cnt_next = wait_cnt + CNT_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      busy_err <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      busy_err <= busy_err_next;
    end
  end

  // tx_data and grant_id only change on a grant, so they stay stable for the whole transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_data    <= '0;
      grant_id   <= 1'b0;
`ifdef UART_ARB_ROUND_ROBIN_EN
      last_grant <= 1'b1;
`endif
    end else begin
      if (grant_take) begin
        tx_data  <= winner ? req1_data : req0_data;
        grant_id <= winner;
      end
`ifdef UART_ARB_ROUND_ROBIN_EN
      if (state == ST_START) last_grant <= grant_id;
`endif
    end
  end

  assign tx_start   = (state == ST_START);
  assign req0_ready = tx_start && !grant_id;
  assign req1_ready = tx_start &&  grant_id;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized traffic
// checked against a pending-request model; honours UART_ARB_ROUND_ROBIN_EN.
module tb_uart_tx_arbiter;

  localparam int DATA_W        = 8;
  localparam int BUSY_WAIT_MAX = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0_valid;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              tx_busy;
  logic              tx_start;
  logic [DATA_W-1:0] tx_data;
  logic              grant_id;
  logic              busy_err;

  int checks   = 0;
  int failures = 0;
  bit m_last;  // model: requester granted most recently (1 after reset)

  logic [DATA_W+3:0] obs;
  logic [DATA_W+3:0] exp;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.DATA_W(DATA_W), .BUSY_WAIT_MAX(BUSY_WAIT_MAX)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .grant_id(grant_id), .busy_err(busy_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Arbitration rule from the requirements: single valid wins; on contention
  // round robin picks the one not granted last, fixed priority picks 0.
  function automatic bit model_pick(input bit v0, input bit v1);
`ifdef UART_ARB_ROUND_ROBIN_EN
    if (v0 && v1) return ~m_last;
`endif
    return v0 ? 1'b0 : 1'b1;
  endfunction

  function automatic logic [DATA_W+3:0] start_vec(input bit w, input logic [DATA_W-1:0] d);
    return {1'b1, ~w, w, w, d};
  endfunction

  // Called in the START cycle; leaves the bench in the following IDLE cycle.
  task automatic finish_transfer(input int delay, input int len);
    step();
    repeat (delay) step();
    tx_busy = 1'b1;
    repeat (len) step();
    tx_busy = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0; req1_data = '0; tx_busy = 1'b0;
    repeat (3) step();
    checks++;
    if ({tx_start, req0_ready, req1_ready, busy_err, grant_id, tx_data} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0",
               {tx_start, req0_ready, req1_ready, busy_err, grant_id, tx_data});
    end
    rst = 1'b0;
    m_last = 1'b1;
  endtask

  task automatic test_single();
    req0_valid = 1'b1; req0_data = 8'h41;
    checks++;
    if (tx_start !== 1'b0) begin
      failures++; $display("FAIL single_idle_start got=%b exp=0", tx_start);
    end
    step();
    obs = {tx_start, req0_ready, req1_ready, grant_id, tx_data};
    exp = start_vec(1'b0, 8'h41);
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL single_start got=%h exp=%h", obs, exp); end
    m_last = 1'b0;
    req0_valid = 1'b0; req0_data = 8'hEE;
    step();
    tx_busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      obs = {tx_start, req0_ready, req1_ready, grant_id, tx_data};
      exp = {4'b0000, 8'h41};
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL single_busy[%0d] got=%h exp=%h", i, obs, exp); end
    end
    tx_busy = 1'b0;
    step();
    // Back in IDLE: a new request must be granted on the very next edge.
    req1_valid = 1'b1; req1_data = 8'h3C;
    step();
    obs = {tx_start, req0_ready, req1_ready, grant_id, tx_data};
    exp = start_vec(1'b1, 8'h3C);
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL single_regrant got=%h exp=%h", obs, exp); end
    m_last = 1'b1;
    req1_valid = 1'b0;
    finish_transfer(1, 2);
  endtask

  task automatic test_contention();
    bit w;
    req0_valid = 1'b1; req0_data = 8'hAA;
    req1_valid = 1'b1; req1_data = 8'h55;
    for (int k = 0; k < 4; k++) begin
      w = model_pick(1'b1, 1'b1);
      step();
      obs = {tx_start, req0_ready, req1_ready, grant_id, tx_data};
      exp = start_vec(w, w ? 8'h55 : 8'hAA);
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL contention[%0d] got=%h exp=%h", k, obs, exp); end
      m_last = w;
      finish_transfer($urandom_range(0, 3), $urandom_range(1, 4));
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_busy_at_request();
    logic [DATA_W-1:0] d;
    d = DATA_W'($urandom);
    tx_busy = 1'b1; req0_valid = 1'b1; req0_data = d;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({tx_start, req0_ready} !== 2'b00) begin
        failures++; $display("FAIL busy_hold[%0d] got=%b exp=00", i, {tx_start, req0_ready});
      end
    end
    tx_busy = 1'b0;
    step();
    obs = {tx_start, req0_ready, req1_ready, grant_id, tx_data};
    exp = start_vec(1'b0, d);
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL busy_release got=%h exp=%h", obs, exp); end
    m_last = 1'b0;
    req0_valid = 1'b0;
    finish_transfer(0, 3);
  endtask

  task automatic test_timeout();
    logic [DATA_W-1:0] d;
    bit w;
    d = DATA_W'($urandom);
    req1_valid = 1'b1; req1_data = d;
    step();
    obs = {tx_start, req0_ready, req1_ready, grant_id, tx_data};
    exp = start_vec(1'b1, d);
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL timeout_start got=%h exp=%h", obs, exp); end
    m_last = 1'b1;
    req1_valid = 1'b0;
    // WAIT_BUSY is entered on the first step; the error pulse follows BUSY_WAIT_MAX edges later.
    for (int i = 1; i <= BUSY_WAIT_MAX + 2; i++) begin
      step();
      checks++;
      if ({busy_err, tx_start, req0_ready, req1_ready} !== {(i == BUSY_WAIT_MAX + 1), 3'b000}) begin
        failures++;
        $display("FAIL timeout_cycle[%0d] got=%b exp=%b", i,
                 {busy_err, tx_start, req0_ready, req1_ready}, {(i == BUSY_WAIT_MAX + 1), 3'b000});
      end
    end
    req0_valid = 1'b1; req0_data = 8'h11;
    req1_valid = 1'b1; req1_data = 8'h22;
    w = model_pick(1'b1, 1'b1);
    step();
    obs = {tx_start, req0_ready, req1_ready, grant_id, tx_data};
    exp = start_vec(w, w ? 8'h22 : 8'h11);
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL timeout_regrant got=%h exp=%h", obs, exp); end
    m_last = w;
    req0_valid = 1'b0; req1_valid = 1'b0;
    finish_transfer(2, 2);
  endtask

  task automatic test_reset_mid();
    logic [DATA_W-1:0] d;
    d = DATA_W'($urandom_range(1, 255));
    req0_valid = 1'b1; req0_data = d;
    step();
    m_last = 1'b0;
    req0_valid = 1'b0;
    step();
    tx_busy = 1'b1;
    step();
    step();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({tx_start, req0_ready, req1_ready, busy_err, grant_id, tx_data} !== '0) begin
      failures++;
      $display("FAIL reset_mid got=%h exp=0",
               {tx_start, req0_ready, req1_ready, busy_err, grant_id, tx_data});
    end
    tx_busy = 1'b0;
    d = DATA_W'($urandom);
    req1_valid = 1'b1; req1_data = d;
    step();
    rst = 1'b0;
    m_last = 1'b1;
    step();
    obs = {tx_start, req0_ready, req1_ready, grant_id, tx_data};
    exp = start_vec(1'b1, d);
    checks++;
    if (obs !== exp) begin failures++; $display("FAIL reset_regrant got=%h exp=%h", obs, exp); end
    req1_valid = 1'b0;
    finish_transfer(0, 2);
  endtask

  task automatic test_random();
    bit                pend [2];
    logic [DATA_W-1:0] pdata[2];
    bit                w;
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i] = 1'b1; pdata[i] = DATA_W'($urandom);
        end
      end
      if (!pend[0] && !pend[1]) begin pend[0] = 1'b1; pdata[0] = DATA_W'($urandom); end
      req0_valid = pend[0]; req0_data = pend[0] ? pdata[0] : DATA_W'($urandom);
      req1_valid = pend[1]; req1_data = pend[1] ? pdata[1] : DATA_W'($urandom);
      w = model_pick(pend[0], pend[1]);
      checks++;
      if (tx_start !== 1'b0) begin failures++; $display("FAIL rand_idle[%0d] got=%b exp=0", r, tx_start); end
      step();
      obs = {tx_start, req0_ready, req1_ready, grant_id, tx_data};
      exp = start_vec(w, pdata[w]);
      checks++;
      if (obs !== exp) begin failures++; $display("FAIL rand_grant[%0d] got=%h exp=%h", r, obs, exp); end
      m_last = w;
      pend[w] = 1'b0;
      if (w) req1_valid = 1'b0; else req0_valid = 1'b0;
      finish_transfer($urandom_range(0, 4), $urandom_range(1, 5));
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_busy_at_request();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
